// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for mem_stream_reader: controller state encoding and the
// default issue-to-stream latency constant.
package mem_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned MEM_LATENCY_DFLT = 2;
    // Cycles from a read issue to the matching word on the stream output.
    localparam int unsigned LATENCY = MEM_LATENCY_DFLT + 1;

endpackage

// File: rtl/mem_stream_reader_delay.sv
// Fixed-length synchronous delay line with synchronous active-high clear.
module mem_stream_reader_delay
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] delayed
);

    logic [DATA_WIDTH-1:0] stages [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign delayed = stages[LATENCY-1];

endmodule

// File: rtl/mem_stream_reader.sv
// Streams a block-RAM address range into a skid FIFO, relying on the receiver's
// skid allowance to absorb RAM latency. Optional MEM_STREAM_READER_CHECKSUM_EN adds chksumOut.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned FIFO_SKID   = 4
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  startIn,
    input  logic [ADDR_WIDTH-1:0] baseAddrIn,
    input  logic [LEN_WIDTH-1:0]  lengthIn,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    output logic                  memRdEnOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic [DATA_WIDTH-1:0] wrDataOut,
    output logic                  wrValidOut,
    input  logic                  wrReadyIn,
    output logic                  busyOut,
    output logic                  doneOut
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] chksumOut
`endif
);

    if (MEM_LATENCY < 1 || MEM_LATENCY + 1 > FIFO_SKID) begin : g_bad_cfg
        $error("mem_stream_reader: need 1 <= MEM_LATENCY and MEM_LATENCY+1 <= FIFO_SKID");
    end

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 2);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0]  length;
    logic [LEN_WIDTH-1:0]  issued;
    logic [CNT_W-1:0]      in_flight;
    logic                  rd_en;
    logic                  data_ok;
    logic                  start_accept;

    always_comb begin
        state_nxt    = state;
        rd_en        = 1'b0;
        start_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (startIn) begin
                    start_accept = 1'b1;
                    state_nxt    = (lengthIn == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Ready only grants permission to issue; the skid absorbs in-flight words.
                if (wrReadyIn) begin
                    rd_en = 1'b1;
                    if (issued == length - LEN_WIDTH'(1)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (in_flight == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state      <= ST_IDLE;
            base       <= '0;
            length     <= '0;
            issued     <= '0;
            in_flight  <= '0;
            wrValidOut <= 1'b0;
            wrDataOut  <= '0;
        end else begin
            state <= state_nxt;
            if (start_accept) begin
                base   <= baseAddrIn;
                length <= lengthIn;
                issued <= '0;
            end else if (rd_en) begin
                issued <= issued + LEN_WIDTH'(1);
            end
            if (rd_en && !data_ok) begin
                in_flight <= in_flight + CNT_W'(1);
            end else if (!rd_en && data_ok) begin
                in_flight <= in_flight - CNT_W'(1);
            end
            wrValidOut <= data_ok;
            if (data_ok) begin
                wrDataOut <= memDataIn;
            end
        end
    end

    mem_stream_reader_delay #(
        .DATA_WIDTH(1),
        .LATENCY   (MEM_LATENCY)
    ) u_rd_delay (
        .clk    (clkIn),
        .rst    (rstIn),
        .data   (rd_en),
        .delayed(data_ok)
    );

    assign memRdEnOut = rd_en;
    assign memAddrOut = base + ADDR_WIDTH'(issued);
    assign busyOut    = (state != ST_IDLE);
    assign doneOut    = (state == ST_DONE);

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    // Accumulated alongside the wrDataOut register so the sum tracks emitted words exactly.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            chksumOut <= '0;
        end else if (start_accept) begin
            chksumOut <= '0;
        end else if (data_ok) begin
            chksumOut <= chksumOut + memDataIn;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized self-checking bench for mem_stream_reader with a registered RAM model,
// a skid-FIFO occupancy model and a reference word stream computed from the RAM image.
module tb_mem_stream_reader;
    import mem_stream_reader_pkg::*;

    localparam int M_CONST  = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_RAND   = 2;
    localparam int M_FIFO   = 3;
    localparam int FDEPTH   = 32;
    localparam int FSKID    = 4;

    logic        clk = 1'b0;
    logic        rstIn, startIn, wrReadyIn;
    logic [9:0]  baseAddrIn, memAddrOut;
    logic [15:0] lengthIn;
    logic        memRdEnOut, wrValidOut, busyOut, doneOut;
    logic [31:0] memDataIn, wrDataOut;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [31:0] chksumOut;
    logic [31:0] chk_at_done, chk_c1;
`endif

    always #5 clk = ~clk;

    mem_stream_reader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .LEN_WIDTH  (16),
        .MEM_LATENCY(2),
        .FIFO_SKID  (4)
    ) dut (
        .clkIn     (clk),
        .rstIn     (rstIn),
        .startIn   (startIn),
        .baseAddrIn(baseAddrIn),
        .lengthIn  (lengthIn),
        .memAddrOut(memAddrOut),
        .memRdEnOut(memRdEnOut),
        .memDataIn (memDataIn),
        .wrDataOut (wrDataOut),
        .wrValidOut(wrValidOut),
        .wrReadyIn (wrReadyIn),
        .busyOut   (busyOut),
        .doneOut   (doneOut)
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        ,
        .chksumOut (chksumOut)
`endif
    );

    // Two-cycle registered-read RAM.
    logic [31:0] ram [1024];
    logic [31:0] d1, d2;
    always @(posedge clk) begin
        d1 <= ram[memAddrOut];
        d2 <= d1;
    end
    assign memDataIn = d2;

    int passed = 0;
    int total  = 0;

    int          rd_cyc[$];
    logic [9:0]  rd_addr[$];
    int          v_cyc[$];
    logic [31:0] v_data[$];
    int          done_cnt, done_cyc, overflow;
    logic        busy_first_rd, busy_after_done;
    bit          timed_out;

    function automatic logic [31:0] exp_word(input logic [9:0] b, input int i);
        return ram[(int'(b) + i) % 1024];
    endfunction

    task automatic fill_identity();
        for (int a = 0; a < 1024; a++) ram[a] = 32'(a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 1024; a++) ram[a] = $urandom;
    endtask

    task automatic run_transfer(input logic [9:0] b, input logic [15:0] len, input int mode,
                                input int pop_pct, input bit hold_start, input int max_cyc);
        int cyc, fcount;
        bit seen_done, fin;
        rd_cyc.delete(); rd_addr.delete(); v_cyc.delete(); v_data.delete();
        done_cnt = 0; done_cyc = -1; overflow = 0; timed_out = 0;
        busy_first_rd = 1'b0; busy_after_done = 1'b1;
        cyc = 0; fcount = 0; seen_done = 0; fin = 0;
        @(posedge clk); #1;
        baseAddrIn = b; lengthIn = len; startIn = 1'b1; wrReadyIn = 1'b1;
        while (!fin) begin
            #1;
            if (memRdEnOut) begin
                if (rd_cyc.size() == 0) busy_first_rd = busyOut;
                rd_cyc.push_back(cyc);
                rd_addr.push_back(memAddrOut);
            end
            if (wrValidOut) begin
                v_cyc.push_back(cyc);
                v_data.push_back(wrDataOut);
                fcount++;
                if (fcount > FDEPTH) overflow++;
            end
            if (mode == M_FIFO && fcount > 0 && $urandom_range(99) < pop_pct) fcount--;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
            if (cyc == 1) chk_c1 = chksumOut;
`endif
            if (seen_done) begin
                busy_after_done = busyOut;
                fin = 1;
            end else if (doneOut) begin
                done_cnt++;
                done_cyc = cyc;
                seen_done = 1;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
                chk_at_done = chksumOut;
`endif
            end
            if (cyc >= max_cyc) begin
                timed_out = 1;
                fin = 1;
            end
            @(posedge clk); #1;
            cyc++;
            startIn = hold_start && !seen_done;
            if (hold_start) begin
                baseAddrIn = b ^ 10'h200;
                lengthIn   = 16'd3;
            end
            case (mode)
                M_TOGGLE: wrReadyIn = (cyc % 2 == 0);
                M_RAND:   wrReadyIn = 1'($urandom_range(1));
                M_FIFO:   wrReadyIn = (fcount < FDEPTH - FSKID);
                default:  wrReadyIn = 1'b1;
            endcase
        end
        startIn = 1'b0;
        wrReadyIn = 1'b0;
    endtask

    task automatic test_reset();
        rstIn = 1'b1; startIn = 1'b0; wrReadyIn = 1'b0; baseAddrIn = '0; lengthIn = '0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({memRdEnOut, wrValidOut, busyOut, doneOut, memAddrOut, wrDataOut} !== '0)
            $display("FAIL reset_outputs: got rd=%b v=%b busy=%b done=%b addr=%0h data=%0h, required all 0",
                     memRdEnOut, wrValidOut, busyOut, doneOut, memAddrOut, wrDataOut);
        else passed++;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        total++;
        if (chksumOut !== '0) $display("FAIL reset_chksum: got %0h required 0", chksumOut);
        else passed++;
`endif
        @(posedge clk); #1;
        rstIn = 1'b0;
    endtask

    task automatic test_directed();
        int bad;
        fill_identity();
        run_transfer(10'h010, 16'd8, M_CONST, 0, 0, 200);
        total++;
        if (timed_out) $display("FAIL directed_timeout: got no doneOut, required doneOut within 200 cycles");
        else passed++;
        total++;
        if (v_data.size() != 8 || rd_cyc.size() != 8)
            $display("FAIL directed_count: got %0d words/%0d reads, required 8/8", v_data.size(), rd_cyc.size());
        else passed++;
        if (v_data.size() == 8 && rd_cyc.size() == 8) begin
            total++;
            if (rd_cyc[0] != 1) $display("FAIL directed_first_rd: got cycle %0d required 1", rd_cyc[0]);
            else passed++;
            total++;
            if (v_cyc[0] - rd_cyc[0] != int'(LATENCY))
                $display("FAIL directed_latency: got %0d required %0d", v_cyc[0] - rd_cyc[0], LATENCY);
            else passed++;
            bad = -1;
            for (int i = 0; i < 8; i++)
                if (bad < 0 && (v_data[i] !== 32'h10 + 32'(i) || v_cyc[i] != v_cyc[0] + i ||
                                rd_addr[i] !== 10'h010 + 10'(i))) bad = i;
            total++;
            if (bad >= 0) $display("FAIL directed_word: idx %0d got data %0h addr %0h, required %0h", bad,
                                   v_data[bad], rd_addr[bad], 32'h10 + 32'(bad));
            else passed++;
            total++;
            if (done_cyc <= v_cyc[7] || done_cyc > v_cyc[7] + 2)
                $display("FAIL directed_done_cycle: got %0d required within 2 cycles after %0d", done_cyc, v_cyc[7]);
            else passed++;
        end
        total++;
        if (busy_first_rd !== 1'b1) $display("FAIL directed_busy: got %b required 1", busy_first_rd);
        else passed++;
        total++;
        if (done_cnt != 1 || busy_after_done !== 1'b0)
            $display("FAIL directed_done_busy: got done=%0d busy_after=%b required 1/0", done_cnt, busy_after_done);
        else passed++;
    endtask

    task automatic test_zero_length();
        run_transfer(10'h123, 16'd0, M_CONST, 0, 0, 50);
        total++;
        if (rd_cyc.size() != 0 || v_data.size() != 0)
            $display("FAIL zero_len_activity: got %0d reads %0d words, required 0/0", rd_cyc.size(), v_data.size());
        else passed++;
        total++;
        if (done_cyc != 1 || done_cnt != 1)
            $display("FAIL zero_len_done: got cycle %0d count %0d, required 1/1", done_cyc, done_cnt);
        else passed++;
    endtask

    task automatic test_throughput_toggle();
        logic [9:0] b;
        int bad;
        fill_random();
        b = 10'($urandom);
        run_transfer(b, 16'd16, M_TOGGLE, 0, 0, 300);
        total++;
        if (v_data.size() != 16) $display("FAIL toggle_count: got %0d required 16", v_data.size());
        else passed++;
        if (v_data.size() == 16) begin
            bad = -1;
            for (int i = 0; i < 16; i++) if (bad < 0 && v_data[i] !== exp_word(b, i)) bad = i;
            total++;
            if (bad >= 0) $display("FAIL toggle_data: idx %0d got %0h required %0h", bad, v_data[bad], exp_word(b, bad));
            else passed++;
            total++;
            if (v_cyc[15] - v_cyc[0] != 30)
                $display("FAIL toggle_rate: got span %0d required 30", v_cyc[15] - v_cyc[0]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [9:0]  b;
        logic [15:0] len;
        int bad;
        fill_random();
        for (int it = 0; it < 6; it++) begin
            b   = 10'($urandom);
            len = 16'($urandom_range(1, 40));
            run_transfer(b, len, M_RAND, 0, 0, 1000);
            bad = (v_data.size() == int'(len) && rd_cyc.size() == int'(len) && !timed_out) ? -1 : -2;
            for (int i = 0; i < int'(len) && bad == -1; i++)
                if (v_data[i] !== exp_word(b, i) || v_cyc[i] != rd_cyc[i] + int'(LATENCY)) bad = i;
            total++;
            if (bad == -2)
                $display("FAIL random_count it%0d: got %0d words required %0d", it, v_data.size(), len);
            else if (bad >= 0)
                $display("FAIL random_word it%0d idx %0d: got %0h at +%0d required %0h at +%0d", it, bad,
                         v_data[bad], v_cyc[bad] - rd_cyc[bad], exp_word(b, bad), LATENCY);
            else passed++;
        end
    endtask

    task automatic test_skid_stress();
        int pct[2] = '{50, 13};
        int bad;
        fill_random();
        for (int p = 0; p < 2; p++) begin
            run_transfer(10'h3F0, 16'd1000, M_FIFO, pct[p], 0, 20000);
            total++;
            if (timed_out || v_data.size() != 1000)
                $display("FAIL skid_count p%0d: got %0d words required 1000", pct[p], v_data.size());
            else passed++;
            total++;
            if (overflow != 0) $display("FAIL skid_overflow p%0d: got %0d overflows required 0", pct[p], overflow);
            else passed++;
            if (v_data.size() == 1000 && rd_addr.size() == 1000) begin
                bad = -1;
                for (int i = 0; i < 1000; i++) if (bad < 0 && v_data[i] !== exp_word(10'h3F0, i)) bad = i;
                total++;
                if (bad >= 0) $display("FAIL skid_data p%0d idx %0d: got %0h required %0h", pct[p], bad,
                                       v_data[bad], exp_word(10'h3F0, bad));
                else passed++;
                total++;
                if (rd_addr[16] !== 10'h000) $display("FAIL skid_wrap: got addr %0h required 0", rd_addr[16]);
                else passed++;
            end
        end
    endtask

    task automatic test_start_while_busy();
        int bad, extra;
        fill_random();
        run_transfer(10'h040, 16'd8, M_CONST, 0, 1, 200);
        bad = (v_data.size() == 8) ? -1 : -2;
        for (int i = 0; i < 8 && bad == -1; i++) if (v_data[i] !== exp_word(10'h040, i)) bad = i;
        total++;
        if (bad != -1) $display("FAIL busy_start_data: first bad idx %0d, got %0d words required 8", bad, v_data.size());
        else passed++;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2;
            if (busyOut || doneOut || memRdEnOut) extra++;
        end
        total++;
        if (done_cnt != 1 || busy_after_done !== 1'b0 || extra != 0)
            $display("FAIL busy_start_done: got done=%0d busy_after=%b extra=%0d required 1/0/0",
                     done_cnt, busy_after_done, extra);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int nrd, guard, seen;
        fill_identity();
        @(posedge clk); #1;
        baseAddrIn = 10'h100; lengthIn = 16'd8; startIn = 1'b1; wrReadyIn = 1'b1;
        nrd = 0; guard = 0;
        while (nrd < 3 && guard < 50) begin
            #1;
            if (memRdEnOut) nrd++;
            @(posedge clk); #1;
            startIn = 1'b0;
            guard++;
        end
        total++;
        if (nrd != 3) $display("FAIL mreset_issue: got %0d reads required 3", nrd);
        else passed++;
        rstIn = 1'b1;
        @(posedge clk); #1;
        rstIn = 1'b0;
        #1;
        total++;
        if ({memRdEnOut, wrValidOut, busyOut, doneOut, memAddrOut, wrDataOut} !== '0)
            $display("FAIL mreset_outputs: got rd=%b v=%b busy=%b done=%b addr=%0h data=%0h, required all 0",
                     memRdEnOut, wrValidOut, busyOut, doneOut, memAddrOut, wrDataOut);
        else passed++;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #2;
            if (wrValidOut || memRdEnOut) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL mreset_quiet: got %0d active cycles required 0", seen);
        else passed++;
        run_transfer(10'h020, 16'd4, M_CONST, 0, 0, 100);
        bad_check: begin
            int bad;
            bad = (v_data.size() == 4 && done_cnt == 1) ? -1 : -2;
            for (int i = 0; i < 4 && bad == -1; i++)
                if (v_data[i] !== 32'h20 + 32'(i) || v_cyc[i] != rd_cyc[i] + int'(LATENCY)) bad = i;
            total++;
            if (bad != -1) $display("FAIL mreset_after: bad idx %0d, got %0d words %0d dones required 4/1",
                                    bad, v_data.size(), done_cnt);
            else passed++;
        end
    endtask

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    task automatic test_checksum();
        int bad;
        logic [31:0] sum;
        ram[10'h080] = 32'd1; ram[10'h081] = 32'd2; ram[10'h082] = 32'd3; ram[10'h083] = 32'hFFFF_FFFF;
        run_transfer(10'h080, 16'd4, M_CONST, 0, 0, 100);
        total++;
        if (chk_at_done !== 32'h5) $display("FAIL chksum_done: got %0h required 5", chk_at_done);
        else passed++;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #2;
            if (chksumOut !== 32'h5) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL chksum_hold: got %0d unstable cycles required 0", bad);
        else passed++;
        run_transfer(10'h010, 16'd2, M_CONST, 0, 0, 100);
        sum = exp_word(10'h010, 0) + exp_word(10'h010, 1);
        total++;
        if (chk_c1 !== 32'h0 || chk_at_done !== sum)
            $display("FAIL chksum_clear: got start=%0h done=%0h required 0/%0h", chk_c1, chk_at_done, sum);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_zero_length();
        test_throughput_toggle();
        test_random();
        test_skid_stress();
        test_start_while_busy();
        test_mid_reset();
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Transmitter end of the skid-buffered write interface used by the accelerator FIFOs (wrData/wrValid/wrReady with FIFO_SKID in-flight allowance).
- On a start command, walks a block-RAM address range, issues reads and pushes each returned word into a downstream skid FIFO.
- Uses the receiver's skid budget to absorb the RAM read latency instead of adding its own buffering.
- Sits between accelerator-local operand RAMs and the input FIFOs of the compute datapath.

Parameters:
- DATA_WIDTH, 32, RAM and stream word width.
- ADDR_WIDTH, 10, RAM word-address width.
- LEN_WIDTH, 16, transfer-length counter width.
- MEM_LATENCY, 2, cycles from memRdEnOut to valid memDataIn; must be >= 1.
- FIFO_SKID, 4, receiver in-flight allowance; elaboration error unless MEM_LATENCY+1 <= FIFO_SKID.

Ports:
- clkIn  in  1  clock.
- rstIn  in  1  reset, synchronous, active-high.
- startIn  in  1  start pulse; sampled only in IDLE.
- baseAddrIn  in  ADDR_WIDTH  first word address.
- lengthIn  in  LEN_WIDTH  number of words to transfer.
- memAddrOut  out  ADDR_WIDTH  RAM read address.
- memRdEnOut  out  1  RAM read enable.
- memDataIn  in  DATA_WIDTH  RAM read data, valid MEM_LATENCY cycles after memRdEnOut.
- wrDataOut  out  DATA_WIDTH  stream data to skid FIFO.
- wrValidOut  out  1  stream valid.
- wrReadyIn  in  1  receiver ready (skid semantics).
- busyOut  out  1  transfer in progress.
- doneOut  out  1  one-cycle completion pulse.

Behaviour:
- Clock is clkIn; reset is rstIn, synchronous and active-high. On reset all outputs are 0, state is IDLE, and the valid pipeline is cleared. Reset mid-transfer drops all in-flight words, and wrValidOut is 0 from the next edge.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - startIn=1 latches baseAddrIn and lengthIn and clears the issued count.
  - If lengthIn==0, go to DONE; otherwise go to ISSUE.
  - busyOut is 0 only in IDLE.
- ISSUE:
  - In each cycle with wrReadyIn=1: memRdEnOut=1, memAddrOut=base+issued (mod 2^ADDR_WIDTH, wraps silently), and issued increments.
  - When wrReadyIn=0, memRdEnOut=0 and memAddrOut holds.
  - Go to DRAIN in the same cycle the last read (issued==length-1) is issued.
- Valid pipeline:
  - memRdEnOut is delayed MEM_LATENCY cycles, then wrValidOut and wrDataOut are registered from memDataIn.
  - Issue-to-wrValidOut latency is exactly MEM_LATENCY+1 cycles.
  - Words are emitted in address order with no gaps other than those caused by ready.
- Handshake:
  - wrReadyIn is a permission to issue, not a per-beat accept.
  - wrValidOut never stalls and is never retracted.
  - The receiver guarantees FIFO_SKID slots after dropping ready, so no data is lost.
- DRAIN: wait until the valid pipeline is empty (last word has emitted), then go to DONE.
- DONE: doneOut=1 for exactly one cycle, then IDLE. A startIn in that same cycle is ignored.
- startIn while busy is ignored; the latched parameters are unaffected.
- lengthIn=2^LEN_WIDTH-1 is supported. The issued counter must not overflow.
- wrReadyIn toggling every cycle gives 50% throughput; a continuous ready gives 1 word/cycle.

Optional Feature:
- Macro: MEM_STREAM_READER_CHECKSUM_EN.
- With the macro defined:
  - Extra port chksumOut, out, DATA_WIDTH.
  - Holds the sum modulo 2^DATA_WIDTH of all words emitted on wrDataOut in the current transfer.
  - Cleared when a start is accepted.
  - Final and stable from the doneOut cycle until the next accepted start.
  - Reset value 0.
- Without the macro: the port and accumulator are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/DRAIN/DONE) and the latency constant LATENCY=MEM_LATENCY+1 used by benches.
- Sub-module: reuse the existing delay module (DATA_WIDTH=1, LATENCY=MEM_LATENCY) for the read-enable-to-valid pipeline. No new sub-module.

Test Plan:
- Directed transfer: base=0x010, len=8, ready held 1, RAM[a]=a. Required: wrValidOut first high 3 cycles after the first rdEn, then 8 consecutive words 0x10..0x17, a doneOut pulse, and busyOut deasserted after done.
- Zero-length start: len=0. Required: no memRdEnOut, no wrValidOut, doneOut one cycle after start.
- Skid stress: drive the real fifo (FIFO_DEPTH=32, FIFO_SKID=4) with random rdReadyIn at 50%/12.5%, and len=1000, base=0x3F0. Required: in-order data with wrap past address 0x3FF to 0x000, no FIFO overflow and no lost word.
- Start while busy: a second startIn mid-transfer with a different base. Required: ignored; the original 8 words are unchanged and there is exactly one doneOut.
- Mid-operation reset: rstIn asserted for 1 cycle after 3 words issued. Required: all outputs 0 next cycle, no further wrValidOut; the next start with len=4 behaves nominally.
- Checksum (with the macro defined): len=4 with data 1,2,3,0xFFFFFFFF. Required: chksumOut=0x00000005 at doneOut, held until the next start.
